mem_unit: RTL

Parametrised single-port data memory for the 8-bit processor, replacing the fixed 256x8 main memory. Adds configurable width and depth, programmable wait states with a ready/valid handshake, and a hardware clear sweep after reset. Sits between the CPU load/store datapath and storage; the CPU stalls on `ready`.

---
 rtl/mem_unit_pkg.sv | 26 ++
 rtl/mem_array.sv | 54 +++++
 rtl/mem_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_unit_pkg
// Purpose  : Shared definitions for the processor data memory: controller
//            state encoding, default CPU word/address widths and the width
//            of the wait-state counter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_unit_pkg;

  // Controller states: power-up clear sweep, waiting for a request, access in flight
  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // Word and address widths of the 8-bit CPU datapath
  localparam int CPU_DATA_WIDTH = 8;
  localparam int CPU_ADDR_WIDTH = 8;

  // Wait counter holds 0..15 extra access cycles
  localparam int WAIT_CNT_WIDTH = 4;

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_array
// Purpose  : DEPTH x DATA_WIDTH storage, one write port and one registered
//            read port. Addresses at or beyond DEPTH are never written and
//            read back as zero.
// Revision : 1.0 - initial release
// ============================================================================
module mem_array
  import mem_unit_pkg::*;
#(
  parameter int DATA_WIDTH = CPU_DATA_WIDTH,
  parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int                IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                 w_in_range;
  logic                 r_in_range;
  logic [IDX_WIDTH-1:0] w_idx;
  logic [IDX_WIDTH-1:0] r_idx;

  // Range checks are done on a zero-extended address so that a full
  // 2^ADDR_WIDTH array compares without overflow.
  assign w_in_range = {1'b0, waddr} < DEPTH_EXT;
  assign r_in_range = {1'b0, raddr} < DEPTH_EXT;
  assign w_idx      = waddr[IDX_WIDTH-1:0];
  assign r_idx      = raddr[IDX_WIDTH-1:0];

  // Single write port; out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (we && w_in_range) begin
      mem[w_idx] <= wdata;
    end
  end

  // Registered read of the presented address every cycle
  always_ff @(posedge clk) begin
    rdata <= r_in_range ? mem[r_idx] : '0;
  end

endmodule
`default_nettype wire

// File: rtl/mem_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_unit
// Purpose  : Parametrised single-port data memory for the 8-bit CPU with a
//            post-reset clear sweep, programmable wait states and a
//            ready-based request handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mem_unit
  import mem_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = CPU_DATA_WIDTH,
  parameter int ADDR_WIDTH  = CPU_ADDR_WIDTH,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  memRead,
  input  logic                  memWrite,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  output logic                  ready,
  output logic                  busy,
  output logic                  addrError
);

  localparam logic [ADDR_WIDTH-1:0]     LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]       DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(WAIT_STATES);

  state_t                    state;
  logic [ADDR_WIDTH-1:0]     clr_ptr;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic                      write_q;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt;

  logic                  addr_ok;
  logic                  finish;
  logic                  commit;
  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_waddr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [ADDR_WIDTH-1:0] arr_raddr;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign addr_ok = {1'b0, addr_q} < DEPTH_EXT;
  assign finish  = (state == ST_ACCESS) && (wait_cnt == '0);
  assign commit  = finish && write_q && addr_ok;

  // The write port is shared by the clear sweep and committed stores.
  // Reset gates it so an access interrupted by reset never lands.
  assign arr_we    = !reset && ((state == ST_CLEAR) || commit);
  assign arr_waddr = (state == ST_CLEAR) ? clr_ptr : addr_q;
  assign arr_wdata = (state == ST_CLEAR) ? '0 : data_q;

  // The read is launched from the live address on the accept edge, so even
  // a zero-wait access has its word ready by the completion edge. Nothing
  // else writes the array during an access, so the early read returns the
  // word as stored at completion.
  assign arr_raddr = (state == ST_IDLE) ? address : addr_q;

  mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (arr_raddr),
    .rdata (arr_rdata)
  );

  // Controller FSM: clear sweep, request accept, wait countdown, completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CLEAR;
      clr_ptr   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      write_q   <= 1'b0;
      wait_cnt  <= '0;
      dataOut   <= '0;
      dataValid <= 1'b0;
      ready     <= 1'b0;
      busy      <= 1'b1;
      addrError <= 1'b0;
    end else begin
      dataValid <= 1'b0;
      addrError <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (clr_ptr == LAST_PTR) begin
            clr_ptr <= '0;
            state   <= ST_IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        ST_IDLE: begin
          if (memRead || memWrite) begin
            addr_q   <= address;
            data_q   <= dataIn;
            write_q  <= memWrite;   // a simultaneous read is dropped
            wait_cnt <= WAIT_LOAD;
            state    <= ST_ACCESS;
            ready    <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            state <= ST_IDLE;
            ready <= 1'b1;
            if (!addr_ok) begin
              addrError <= 1'b1;
            end
            if (!write_q) begin
              dataOut   <= addr_ok ? arr_rdata : '0;
              dataValid <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_CLEAR;
          busy  <= 1'b1;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
